jk_bank_ctrl: RTL

Command-driven sequencer for a bank of WIDTH JK flip-flop cells held inside the block. The controller accepts one command at a time over a valid/ready handshake. Each command expands into one or more cycles of per-bit J/K drive, supporting clear, set, toggle, load, increment and decrement. It sits between a host/test FSM and the JK storage, and exposes the generated J/K vectors for observation.

---
 rtl/jk_bank_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving a bank of JK cells: each accepted command expands
// into one or more cycles of per-bit J/K drive (clear/set/toggle/load/inc/dec).
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LW-1:0]    cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_SET  = 3'd2;
    localparam logic [2:0] OP_TGL  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_INC  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [LW-1:0]    r_rem;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_accept;
    logic             w_run;
    logic             w_multi;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_inc_t;
    logic [WIDTH-1:0] w_dec_t;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign w_multi  = (cmd_op == OP_TGL) || (cmd_op == OP_INC) || (cmd_op == OP_DEC);

    // Counter toggle masks: a bit flips when every lower bit is 1 (INC) or 0 (DEC).
    assign w_inc_t[0] = 1'b1;
    assign w_dec_t[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tmask
            assign w_inc_t[gi] = w_inc_t[gi-1] &  r_q[gi-1];
            assign w_dec_t[gi] = w_dec_t[gi-1] & ~r_q[gi-1];
        end
    endgenerate

    always_comb begin
        w_j = '0;
        w_k = '0;
        case (r_op)
            OP_CLR:  begin w_j = '0;      w_k = r_data;  end
            OP_SET:  begin w_j = r_data;  w_k = '0;      end
            OP_TGL:  begin w_j = r_data;  w_k = r_data;  end
            OP_LOAD: begin w_j = r_data;  w_k = ~r_data; end
            OP_INC:  begin w_j = w_inc_t; w_k = w_inc_t; end
            OP_DEC:  begin w_j = w_dec_t; w_k = w_dec_t; end
            default: begin w_j = '0;      w_k = '0;      end
        endcase
    end

    // Outside RUN the cells see J=K=0 and simply hold.
    assign j_out = w_run ? w_j : '0;
    assign k_out = w_run ? w_k : '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_cell
            assign w_q_next[gi] = (j_out[gi] & ~r_q[gi]) | (~k_out[gi] & r_q[gi]);
        end
    endgenerate

    assign w_wrap_next = w_run &&
                         (((r_op == OP_INC) && (&r_q)) ||
                          ((r_op == OP_DEC) && (~|r_q)));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((cmd_op == OP_NOP) || (cmd_op == OP_RSV)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_rem == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready = 1'b1;
            S_DONE: begin
                done = 1'b1;
                err  = (r_op == OP_RSV);
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Command capture, repeat counter, JK bank and wrap flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op   <= OP_NOP;
            r_data <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_rem  <= w_multi ? cmd_len : '0;
            end else if (w_run && (r_rem != '0)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule
